// File: rtl/udma_i2c_rx_packer.sv
// I2C uDMA receive packer: packs the RX byte stream into little-endian words of a
// runtime datasize and queues them in a small first-word-fall-through FIFO.
module udma_i2c_rx_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOG_DEPTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  flush_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            data_datasize_o,
  output logic [2:0]            data_bytes_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [LOG_DEPTH:0]    fifo_count_o
);

  localparam logic [2:0]         MaxN     = 3'(DATA_WIDTH / 8);
  localparam logic [LOG_DEPTH:0] DepthCnt = (LOG_DEPTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_merged, push_data;
  logic [2:0]            cnt_q, cnt_d, cnt_acc, tgt_q, tgt_d, n_raw, n_cfg, n_word, push_bytes;
  logic [1:0]            ds_q, ds_d, ds_eff, ds_cfg, ds_word, push_ds;
  logic                  flush_pending_q, flush_pending_d;
  logic [LOG_DEPTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]    count_q, count_d;
  logic                  full, empty, pop, push, accept, first;

  logic [DATA_WIDTH-1:0] mem_data_q  [FIFO_DEPTH];
  logic [1:0]            mem_ds_q    [FIFO_DEPTH];
  logic [2:0]            mem_bytes_q [FIFO_DEPTH];

  always_comb begin
    ds_eff = (cfg_datasize_i == 2'd3) ? 2'd2 : cfg_datasize_i;
    n_raw  = 3'd1 << ds_eff;
    n_cfg  = (n_raw > MaxN) ? MaxN : n_raw;
    // Report the datasize actually used after capping to the word width.
    ds_cfg = (n_cfg == 3'd1) ? 2'd0 : ((n_cfg == 3'd2) ? 2'd1 : 2'd2);

    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    pop          = !empty && data_ready_i && !clr_i;
    byte_ready_o = !full && !flush_pending_q;
    accept       = byte_valid_i && byte_ready_o;
    first        = (cnt_q == 3'd0);
    n_word       = first ? n_cfg : tgt_q;
    ds_word      = first ? ds_cfg : ds_q;
    acc_merged   = acc_q | (DATA_WIDTH'(byte_i) << {cnt_q, 3'b000});
    cnt_acc      = cnt_q + 3'd1;

    push            = 1'b0;
    push_data       = acc_q;
    push_bytes      = cnt_q;
    push_ds         = ds_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    tgt_d           = tgt_q;
    ds_d            = ds_q;
    flush_pending_d = flush_pending_q;

    if (flush_pending_q) begin
      if (!full || pop) begin
        push            = 1'b1;
        acc_d           = '0;
        cnt_d           = 3'd0;
        flush_pending_d = 1'b0;
      end
    end else begin
      if (accept) begin
        acc_d      = acc_merged;
        cnt_d      = cnt_acc;
        tgt_d      = n_word;
        ds_d       = ds_word;
        push_data  = acc_merged;
        push_bytes = cnt_acc;
        push_ds    = ds_word;
        if (cnt_acc == n_word) begin
          push  = 1'b1;
          acc_d = '0;
          cnt_d = 3'd0;
        end
      end
      // A flush only emits what is still pending after the byte of this cycle.
      if (flush_i && !push && (cnt_d != 3'd0)) begin
        if (!full) begin
          push  = 1'b1;
          acc_d = '0;
          cnt_d = 3'd0;
        end else begin
          flush_pending_d = 1'b1;
        end
      end
    end
    if (clr_i) push = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q           <= '0;
      cnt_q           <= 3'd0;
      tgt_q           <= 3'd1;
      ds_q            <= 2'd0;
      flush_pending_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else if (clr_i) begin
      acc_q           <= '0;
      cnt_q           <= 3'd0;
      tgt_q           <= 3'd1;
      ds_q            <= 2'd0;
      flush_pending_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      tgt_q           <= tgt_d;
      ds_q            <= ds_d;
      flush_pending_q <= flush_pending_d;
      count_q         <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_ds_q[wr_ptr_q]    <= push_ds;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign data_valid_o    = !empty;
  assign data_o          = empty ? '0 : mem_data_q[rd_ptr_q];
  assign data_datasize_o = empty ? 2'd0 : mem_ds_q[rd_ptr_q];
  assign data_bytes_o    = empty ? 3'd0 : mem_bytes_q[rd_ptr_q];
  assign fifo_count_o    = count_q;

endmodule

// File: tb/tb_udma_i2c_rx_packer.sv
// Bench for udma_i2c_rx_packer: directed scenarios plus randomized traffic checked
// against a byte-queue / word-queue reference model.
module tb_udma_i2c_rx_packer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr, flush, bv, dready, ready_o, dvalid;
  logic [1:0]  cfg_ds, dds;
  logic [7:0]  byte_d;
  logic [31:0] data;
  logic [2:0]  dbytes, count;

  int errors = 0;
  int checks = 0;

  udma_i2c_rx_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .cfg_datasize_i(cfg_ds), .flush_i(flush),
    .byte_i(byte_d), .byte_valid_i(bv), .byte_ready_o(ready_o), .data_o(data),
    .data_datasize_o(dds), .data_bytes_o(dbytes), .data_valid_o(dvalid),
    .data_ready_i(dready), .fifo_count_o(count)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes of the current word and the list of queued words.
  typedef struct {logic [31:0] data; logic [1:0] ds; logic [2:0] nb;} word_t;
  logic [7:0] acc_m[$];
  word_t      fifo_m[$];
  int         n_m, ds_m, sz, eff;
  bit         pend_m, pop_m, did_m;

  function automatic word_t mk_word();
    word_t w;
    w.data = 32'h0;
    foreach (acc_m[k]) w.data = w.data + (32'(acc_m[k]) << (8 * k));
    w.ds = 2'(ds_m);
    w.nb = 3'(acc_m.size());
    return w;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clr) begin
      acc_m.delete(); fifo_m.delete(); pend_m = 0;
    end else begin
      sz = fifo_m.size(); pop_m = (sz > 0) && dready; did_m = 0;
      if (pend_m) begin
        if (sz < D || pop_m) begin fifo_m.push_back(mk_word()); acc_m.delete(); pend_m = 0; end
      end else begin
        if (bv && sz < D) begin
          if (acc_m.size() == 0) begin
            eff = (cfg_ds == 2'd3) ? 2 : int'(cfg_ds); n_m = 1 << eff; ds_m = eff;
          end
          acc_m.push_back(byte_d);
          if (acc_m.size() == n_m) begin
            fifo_m.push_back(mk_word()); acc_m.delete(); did_m = 1;
          end
        end
        if (flush && !did_m && acc_m.size() > 0) begin
          if (sz < D) begin fifo_m.push_back(mk_word()); acc_m.delete(); end
          else pend_m = 1;
        end
      end
      if (pop_m) void'(fifo_m.pop_front());
    end
  end

  task automatic drive(input bit v, input logic [7:0] b, input bit f, input bit r,
                       input logic [1:0] ds, input bit c);
    bv = v; byte_d = b; flush = f; dready = r; cfg_ds = ds; clr = c;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    drive(0, 8'h00, 0, 0, cfg_ds, 0);
  endtask

  task automatic do_clr;
    drive(0, 8'h00, 0, 0, 2'd0, 1); tick; idle;
  endtask

  task automatic test_reset;
    rstn = 1'b0; drive(0, 8'h00, 0, 0, 2'd0, 0);
    #3;
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dvalid); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
    checks++; if (dds !== 2'd0) begin errors++; $display("FAIL reset_ds: got %0d want 0", dds); end
    checks++; if (dbytes !== 3'd0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", dbytes); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    @(negedge clk); rstn = 1'b1; tick;
  endtask

  task automatic test_pack_word;
    logic [7:0] bs[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, bs[i], 0, 0, 2'd2, 0); tick;
      if (i == 2) begin
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL pack_early_valid: got %b want 0", dvalid); end
      end
    end
    idle;
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL pack_valid: got %b want 1", dvalid); end
    checks++; if (data !== 32'h44332211) begin errors++; $display("FAIL pack_data: got %h want 44332211", data); end
    checks++; if (dbytes !== 3'd4) begin errors++; $display("FAIL pack_bytes: got %0d want 4", dbytes); end
    checks++; if (dds !== 2'd2) begin errors++; $display("FAIL pack_ds: got %0d want 2", dds); end
    drive(0, 8'h00, 0, 1, 2'd2, 0); tick; idle;
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL pack_pop_valid: got %b want 0", dvalid); end
  endtask

  task automatic test_flush;
    drive(1, 8'hAA, 0, 0, 2'd1, 0); tick;
    drive(1, 8'hBB, 0, 0, 2'd1, 0); tick;
    drive(1, 8'hCC, 0, 0, 2'd1, 0); tick;
    drive(0, 8'h00, 1, 0, 2'd1, 0); tick; idle;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_count: got %0d want 2", count); end
    checks++; if (data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_w0: got %h want 0000bbaa", data); end
    checks++; if (dbytes !== 3'd2) begin errors++; $display("FAIL flush_w0_bytes: got %0d want 2", dbytes); end
    drive(0, 8'h00, 0, 1, 2'd1, 0); tick; idle;
    checks++; if (data !== 32'h000000CC) begin errors++; $display("FAIL flush_w1: got %h want 000000cc", data); end
    checks++; if (dbytes !== 3'd1) begin errors++; $display("FAIL flush_w1_bytes: got %0d want 1", dbytes); end
    checks++; if (dds !== 2'd1) begin errors++; $display("FAIL flush_w1_ds: got %0d want 1", dds); end
    do_clr;
  endtask

  task automatic test_backpressure;
    for (int i = 1; i <= 4; i++) begin drive(1, 8'(i), 0, 0, 2'd0, 0); tick; end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count: got %0d want 4", count); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", ready_o); end
    drive(1, 8'h05, 0, 0, 2'd0, 0); tick;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_held: got %0d want 4", count); end
    drive(1, 8'h05, 0, 1, 2'd0, 0); tick;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bp_pop_count: got %0d want 3", count); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: got %b want 1", ready_o); end
    checks++; if (data !== 32'h2) begin errors++; $display("FAIL bp_head: got %h want 2", data); end
    drive(1, 8'h05, 0, 0, 2'd0, 0); tick; idle;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_accept5: got %0d want 4", count); end
    drive(0, 8'h00, 0, 1, 2'd0, 0); repeat (3) tick; idle;
    checks++; if (data !== 32'h5) begin errors++; $display("FAIL bp_last: got %h want 5", data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_last_count: got %0d want 1", count); end
    do_clr;
  endtask

  task automatic test_flush_near_full;
    for (int i = 1; i <= 3; i++) begin drive(1, 8'(i), 0, 0, 2'd0, 0); tick; end
    drive(1, 8'h5A, 0, 0, 2'd2, 0); tick;
    drive(1, 8'h6B, 0, 0, 2'd2, 0); tick;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fnf_partial_count: got %0d want 3", count); end
    drive(0, 8'h00, 1, 0, 2'd2, 0); tick; idle;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fnf_flush_count: got %0d want 4", count); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fnf_full_ready: got %b want 0", ready_o); end
    drive(0, 8'h00, 1, 0, 2'd2, 0); tick; idle;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fnf_empty_flush: got %0d want 4", count); end
    drive(0, 8'h00, 0, 1, 2'd2, 0); tick; idle;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fnf_no_pending: got %b want 1", ready_o); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fnf_pop_count: got %0d want 3", count); end
    drive(0, 8'h00, 0, 1, 2'd2, 0); repeat (2) tick; idle;
    checks++; if (data !== 32'h00006B5A) begin errors++; $display("FAIL fnf_word: got %h want 00006b5a", data); end
    checks++; if (dbytes !== 3'd2) begin errors++; $display("FAIL fnf_bytes: got %0d want 2", dbytes); end
    checks++; if (dds !== 2'd2) begin errors++; $display("FAIL fnf_ds: got %0d want 2", dds); end
    do_clr;
  endtask

  task automatic test_cfg_change;
    drive(1, 8'h01, 0, 0, 2'd2, 0); tick;
    for (int i = 2; i <= 4; i++) begin drive(1, 8'(i), 0, 0, 2'd0, 0); tick; end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL cfg_count: got %0d want 1", count); end
    checks++; if (data !== 32'h04030201) begin errors++; $display("FAIL cfg_word: got %h want 04030201", data); end
    checks++; if (dds !== 2'd2) begin errors++; $display("FAIL cfg_ds: got %0d want 2", dds); end
    drive(1, 8'h05, 0, 0, 2'd0, 0); tick; idle;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL cfg_single_count: got %0d want 2", count); end
    drive(0, 8'h00, 0, 1, 2'd0, 0); tick; idle;
    checks++; if (data !== 32'h5) begin errors++; $display("FAIL cfg_single: got %h want 5", data); end
    checks++; if (dbytes !== 3'd1 || dds !== 2'd0) begin
      errors++; $display("FAIL cfg_single_fmt: got bytes=%0d ds=%0d want 1/0", dbytes, dds);
    end
    do_clr;
  endtask

  task automatic test_clr;
    for (int i = 1; i <= 3; i++) begin drive(1, 8'(i), 0, 0, 2'd0, 0); tick; end
    drive(1, 8'hEE, 0, 0, 2'd2, 0); tick;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL clr_pre_count: got %0d want 3", count); end
    drive(1, 8'h77, 0, 0, 2'd2, 1); tick; idle;
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", dvalid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", ready_o); end
    for (int i = 1; i <= 4; i++) begin drive(1, 8'(i * 16), 0, 0, 2'd2, 0); tick; end
    idle;
    checks++; if (data !== 32'h40302010) begin errors++; $display("FAIL clr_fresh: got %h want 40302010", data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL clr_fresh_count: got %0d want 1", count); end
    do_clr;
  endtask

  task automatic test_reset_midop;
    drive(1, 8'hA1, 0, 0, 2'd0, 0); tick;
    drive(1, 8'hA2, 0, 0, 2'd0, 0); tick;
    drive(1, 8'hB1, 0, 0, 2'd2, 0); tick; idle;
    #2 rstn = 1'b0; #1;
    checks++; if (dvalid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_mid: got valid=%b count=%0d want 0/0", dvalid, count);
    end
    @(negedge clk); rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin drive(1, 8'(8'hC0 + i), 0, 0, 2'd2, 0); tick; end
    idle;
    checks++; if (data !== 32'hC4C3C2C1) begin errors++; $display("FAIL rst_fresh: got %h want c4c3c2c1", data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rst_fresh_count: got %0d want 1", count); end
    do_clr;
  endtask

  task automatic test_random;
    int rdy_pct;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) rdy_pct = $urandom_range(10, 90);
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) < rdy_pct, 2'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
      tick;
      checks++; if (dvalid !== (fifo_m.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, dvalid, fifo_m.size() != 0);
      end
      checks++; if (count !== 3'(fifo_m.size())) begin
        errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, count, fifo_m.size());
      end
      checks++; if (ready_o !== (fifo_m.size() < D && !pend_m)) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, ready_o, fifo_m.size() < D && !pend_m);
      end
      if (fifo_m.size() != 0) begin
        checks++; if (data !== fifo_m[0].data || dbytes !== fifo_m[0].nb || dds !== fifo_m[0].ds) begin
          errors++;
          $display("FAIL rnd_head cyc %0d: got %h/%0d/%0d want %h/%0d/%0d", cyc, data, dbytes, dds,
                   fifo_m[0].data, fifo_m[0].nb, fifo_m[0].ds);
        end
      end
    end
    do_clr;
  endtask

  initial begin
    test_reset;
    test_pack_word;
    test_flush;
    test_backpressure;
    test_flush_near_full;
    test_cfg_change;
    test_clr;
    test_reset_midop;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udma_i2c_rx_packer.md
Name: udma_i2c_rx_packer

Overview:
- Receive-side data packer for the next-generation I2C uDMA channel, in the peripheral clock domain between the I2C control FSM byte output and the RX clock-domain-crossing FIFO.
- Packs the 8-bit RX byte stream into DATA_WIDTH-bit little-endian words of a runtime-selected datasize (byte/half/word), so L2 transfers are no longer byte-only.
- Buffers packed words in a FIFO_DEPTH-entry FIFO.
- Supports a flush on STOP that emits a zero-padded partial word.

Parameters:
- DATA_WIDTH, 32, output word width; multiple of 8, range 8..32.
- FIFO_DEPTH, 4, packed-word FIFO entries; power of 2, ≥2.
- LOG_DEPTH, $clog2(FIFO_DEPTH), derived; not to be overridden.

Ports:
- clk_i  in  1  peripheral clock.
- rstn_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear of accumulator, FIFO and flush state.
- cfg_datasize_i  in  2  0=1 byte, 1=2 bytes, 2/3=4 bytes; capped to DATA_WIDTH/8.
- flush_i  in  1  single-cycle pulse: emit the pending partial word.
- byte_i  in  8  RX byte from the I2C control FSM.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  byte accepted when byte_valid_i && byte_ready_o.
- data_o  out  DATA_WIDTH  packed word at FIFO head.
- data_datasize_o  out  2  datasize the head word was packed with.
- data_bytes_o  out  3  valid bytes in the head word (1..DATA_WIDTH/8).
- data_valid_o  out  1  FIFO non-empty.
- data_ready_i  in  1  head word popped when data_valid_o && data_ready_i.
- fifo_count_o  out  LOG_DEPTH+1  FIFO occupancy.

Behaviour:
- Reset values: data_valid_o=0, data_o=0, data_datasize_o=0, data_bytes_o=0, fifo_count_o=0, byte_ready_o=1. Accumulator empty, flush_pending=0.
- Effective target byte count N = min(2^cfg_datasize_i, DATA_WIDTH/8), with datasize 3 treated as 2.
- N and its datasize are latched when the first byte of a word is accepted. cfg changes while the accumulator is non-empty take effect from the next word.
- Byte k of a word (k=0 first) is placed at bits [8k+7:8k]. Unfilled bytes are 0.
- byte_ready_o = !fifo_full && !flush_pending. This is combinational and has no bypass on a same-cycle pop.
- Word push: when the accepted byte makes count==N, the word is written into the FIFO with data_bytes_o=N and the accumulator is cleared in the same edge. data_valid_o rises the next cycle if the FIFO was empty (1-cycle latency).
- Flush with count==0 and no byte accepted: no effect.
- Flush with a partial word (0<count<N): the word is pushed with data_bytes_o=count and the latched datasize.
  - If the FIFO is full, set flush_pending. The push happens on the first cycle with space; flush_pending then clears.
- Flush coincident with an accepted byte: the byte is included first.
  - If that byte completes the word, a normal push occurs and no extra word is emitted.
  - Otherwise the partial word including the byte is pushed.
- flush_i while flush_pending is already set: ignored.
- FIFO: first-word-fall-through, registered storage, pointer wrap at FIFO_DEPTH.
  - Simultaneous push and pop when full: pop occurs, push is not possible because byte_ready_o=0.
  - A pending flush may push in the same cycle as a pop on a full FIFO. Occupancy stays FIFO_DEPTH.
- fifo_count_o increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- clr_i has priority over all other inputs. Next cycle: accumulator empty, FIFO empty, flush_pending=0, data_valid_o=0. Bytes offered in the clr cycle are dropped.
- Reset mid-operation: all state returns to reset values asynchronously. No partial word is emitted.

Test Plan:
- DATA_WIDTH=32, datasize=2; bytes 0x11,0x22,0x33,0x44 back-to-back -> one word 0x44332211, data_bytes_o=4, data_datasize_o=2, data_valid_o high 1 cycle after the 4th byte.
- datasize=1; bytes 0xAA,0xBB,0xCC then flush_i -> words 0x0000BBAA (bytes=2), then 0x000000CC (bytes=1, datasize=1).
- datasize=0, data_ready_i=0; push 5 bytes at FIFO_DEPTH=4 -> fifo_count_o=4, byte_ready_o=0 after the 4th byte, 5th byte held. One pop -> 5th byte accepted next cycle.
- FIFO full, datasize=2, 2 bytes pending, flush_i pulsed -> byte_ready_o stays 0. After one pop, word 0x0000xxyy with bytes=2 pushed; flush_pending cleared.
- cfg_datasize_i changed 2→0 after the 1st byte of a word -> that word completes at 4 bytes; the following bytes emit as single-byte words.
- clr_i asserted with 3 FIFO entries and 1 partial byte -> next cycle data_valid_o=0, fifo_count_o=0. The next 4 bytes form a fresh word with no stale data.
